// File: rtl/fb_pkg.sv
// Shared constants and types for the rectangle-fill engine.
// Framebuffer is 640x480 pixels, 8-bit intensity, stored column-major.
package fb_pkg;

  localparam int H_RES    = 640;
  localparam int V_RES    = 480;
  localparam int FB_DEPTH = H_RES * V_RES;
  localparam int FB_AW    = $clog2(FB_DEPTH);

  typedef logic [FB_AW-1:0] fb_addr_t;
  typedef logic [7:0]       pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } fill_state_t;

  // Sized forms of the screen limits, for width-clean compares against coordinates.
  localparam logic [9:0] H_LIM    = 10'(H_RES);
  localparam logic [8:0] V_LIM    = 9'(V_RES);
  localparam fb_addr_t   COL_STEP = fb_addr_t'(V_RES);

  // Word address of pixel (x, y): y + x*480, with x*480 = x*512 - x*32.
  function automatic fb_addr_t pixel_addr(input logic [9:0] x, input logic [8:0] y);
    return (fb_addr_t'(x) << 9) - (fb_addr_t'(x) << 5) + fb_addr_t'(y);
  endfunction

endpackage

// File: rtl/fb_fill_regs.sv
// Avalon-MM register file for the rectangle-fill engine: parameter
// registers, control strobes (start, clear-done), done flag and status readback.
// Optional feature: FB_RECT_FILL_IRQ_EN drives irq from the done flag;
// otherwise irq is tied low.
module fb_fill_regs
  import fb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       chipselect,
  input  logic       write,
  input  logic       read,
  input  logic [3:0] address,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  input  logic       busy,
  input  logic       set_done,
  output logic       start,
  output logic [7:0] color,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic [9:0] w,
  output logic [8:0] h,
  output logic       irq
);

  pixel_t     color_q, color_d;
  logic [9:0] x_q, x_d, w_q, w_d;
  logic [8:0] y_q, y_d, h_q, h_d;
  logic       done_q, done_d;

  logic wr_en;
  logic ctrl_wr;
  logic unused_read;

  // Reads have zero wait states and no side effects, so the strobe carries no information.
  assign unused_read = read;

  assign wr_en   = chipselect & write;
  assign ctrl_wr = wr_en && (address == 4'd9);
  assign start   = ctrl_wr & writedata[0];

  // Next-state for the parameter registers and the done flag.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    color_d = color_q;
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    h_d     = h_q;
    done_d  = done_q;
    if (wr_en) begin
      case (address)
        4'd0:    color_d = writedata;
        4'd1:    x_d = {writedata[1:0], x_q[7:0]};
        4'd2:    x_d = {x_q[9:8], writedata};
        4'd3:    y_d = {writedata[0], y_q[7:0]};
        4'd4:    y_d = {y_q[8], writedata};
        4'd5:    w_d = {writedata[1:0], w_q[7:0]};
        4'd6:    w_d = {w_q[9:8], writedata};
        4'd7:    h_d = {writedata[0], h_q[7:0]};
        4'd8:    h_d = {h_q[8], writedata};
        default: ;
      endcase
    end
    if (ctrl_wr && writedata[1]) done_d = 1'b0;
    // Completion wins over a simultaneous clear so a finished fill is never lost.
    if (set_done) done_d = 1'b1;
  end

  // Register storage.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: these are a handful of flops, not a RAM, so each one can take the async reset.
    if (!reset_n) begin
      color_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      color_q <= color_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      done_q  <= done_d;
    end
  end

  // Combinational readback; hi registers show only their implemented bits.
  always_comb begin
    readdata = 8'h00;
    case (address)
      4'd0:    readdata = color_q;
      4'd1:    readdata = {6'b0, x_q[9:8]};
      4'd2:    readdata = x_q[7:0];
      4'd3:    readdata = {7'b0, y_q[8]};
      4'd4:    readdata = y_q[7:0];
      4'd5:    readdata = {6'b0, w_q[9:8]};
      4'd6:    readdata = w_q[7:0];
      4'd7:    readdata = {7'b0, h_q[8]};
      4'd8:    readdata = h_q[7:0];
      4'd9:    readdata = {6'b0, done_q, busy};
      default: readdata = 8'h00;
    endcase
  end

  assign color = color_q;
  assign x     = x_q;
  assign y     = y_q;
  assign w     = w_q;
  assign h     = h_q;

`ifdef FB_RECT_FILL_IRQ_EN
  assign irq = done_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle-fill engine: walks a clipped rectangle column by column and
// issues one framebuffer write per pixel with a ready/valid handshake.
// Optional feature: FB_RECT_FILL_IRQ_EN enables the level completion interrupt.
module fb_rect_fill
  import fb_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [3:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  output logic        fb_we,
  output logic [18:0] fb_addr,
  output logic [7:0]  fb_data,
  input  logic        fb_ready,
  output logic        irq
);

  logic       start, busy, set_done;
  logic [7:0] reg_color;
  logic [9:0] reg_x, reg_w;
  logic [8:0] reg_y, reg_h;

  fb_fill_regs u_regs (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .write      (write),
    .read       (read),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .busy       (busy),
    .set_done   (set_done),
    .start      (start),
    .color      (reg_color),
    .x          (reg_x),
    .y          (reg_y),
    .w          (reg_w),
    .h          (reg_h),
    .irq        (irq)
  );

  fill_state_t state_q, state_d;
  logic        fb_we_q, fb_we_d;
  fb_addr_t    fb_addr_q, fb_addr_d;
  pixel_t      fb_data_q, fb_data_d;
  fb_addr_t    col_base_q, col_base_d;
  logic [9:0]  x_cur_q, x_cur_d, x_end_q, x_end_d;
  logic [8:0]  y_cur_q, y_cur_d, y_start_q, y_start_d, y_end_q, y_end_d;

  logic [10:0] x_sum;
  logic [9:0]  y_sum;
  logic        empty_rect;

  assign x_sum      = {1'b0, reg_x} + {1'b0, reg_w};
  assign y_sum      = {1'b0, reg_y} + {1'b0, reg_h};
  assign empty_rect = (reg_w == '0) || (reg_h == '0) || (reg_x >= H_LIM) || (reg_y >= V_LIM);

  assign busy     = (state_q != IDLE);
  assign set_done = (state_q == DONE);

  // FSM and address generator next-state.
  always_comb begin
    state_d    = state_q;
    fb_we_d    = fb_we_q;
    fb_addr_d  = fb_addr_q;
    fb_data_d  = fb_data_q;
    col_base_d = col_base_q;
    x_cur_d    = x_cur_q;
    x_end_d    = x_end_q;
    y_cur_d    = y_cur_q;
    y_start_d  = y_start_q;
    y_end_d    = y_end_q;
    case (state_q)
      IDLE: if (start) state_d = SETUP;
      SETUP: begin
        // Snapshot the registers so later register writes cannot disturb this fill.
        x_end_d    = (x_sum > {1'b0, H_LIM}) ? H_LIM : x_sum[9:0];
        y_end_d    = (y_sum > {1'b0, V_LIM}) ? V_LIM : y_sum[8:0];
        x_cur_d    = reg_x;
        y_cur_d    = reg_y;
        y_start_d  = reg_y;
        col_base_d = pixel_addr(reg_x, reg_y);
        fb_addr_d  = pixel_addr(reg_x, reg_y);
        fb_data_d  = reg_color;
        if (empty_rect) begin
          state_d = DONE;
        end else begin
          state_d = FILL;
          fb_we_d = 1'b1;
        end
      end
      FILL: begin
        if (fb_ready) begin
          if (y_cur_q + 9'd1 == y_end_q) begin
            if (x_cur_q + 10'd1 == x_end_q) begin
              state_d = DONE;
              fb_we_d = 1'b0;
            end else begin
              x_cur_d    = x_cur_q + 10'd1;
              y_cur_d    = y_start_q;
              col_base_d = col_base_q + COL_STEP;
              fb_addr_d  = col_base_q + COL_STEP;
            end
          end else begin
            y_cur_d   = y_cur_q + 9'd1;
            fb_addr_d = fb_addr_q + fb_addr_t'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state, walk counters and registered framebuffer outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
      col_base_q <= '0;
      x_cur_q    <= '0;
      x_end_q    <= '0;
      y_cur_q    <= '0;
      y_start_q  <= '0;
      y_end_q    <= '0;
    end else begin
      state_q    <= state_d;
      fb_we_q    <= fb_we_d;
      fb_addr_q  <= fb_addr_d;
      fb_data_q  <= fb_data_d;
      col_base_q <= col_base_d;
      x_cur_q    <= x_cur_d;
      x_end_q    <= x_end_d;
      y_cur_q    <= y_cur_d;
      y_start_q  <= y_start_d;
      y_end_q    <= y_end_d;
    end
  end

  assign fb_we   = fb_we_q;
  assign fb_addr = fb_addr_q;
  assign fb_data = fb_data_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed self-checking bench for fb_rect_fill.
module tb_fb_rect_fill;

`ifdef FB_RECT_FILL_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [3:0]  address = 4'd0;
  logic [7:0]  writedata = 8'd0;
  logic [7:0]  readdata;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_ready = 1'b1;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  logic [26:0] acc_q[$];
  logic        stall_prev = 1'b0;
  logic [18:0] st_addr;
  logic [7:0]  st_data;

  logic [18:0] exp_a1[$] = '{19'd0, 19'd1, 19'd2, 19'd480, 19'd481, 19'd482};
  logic [18:0] exp_a2[$] = '{19'd306718, 19'd306719, 19'd307198, 19'd307199};
  logic [18:0] exp_a5[$] = '{19'd4820, 19'd4821, 19'd4822, 19'd4823,
                             19'd5300, 19'd5301, 19'd5302, 19'd5303,
                             19'd5780, 19'd5781, 19'd5782, 19'd5783,
                             19'd6260, 19'd6261, 19'd6262, 19'd6263};

  fb_rect_fill dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .write      (write),
    .read       (read),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_ready   (fb_ready),
    .irq        (irq)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Accept recorder and stall-stability monitor, sampling pre-edge values.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev && fb_we) begin
        check("stall_addr_stable", {13'b0, fb_addr}, {13'b0, st_addr});
        check("stall_data_stable", {24'b0, fb_data}, {24'b0, st_data});
      end
      if (fb_we && fb_ready) acc_q.push_back({fb_addr, fb_data});
      stall_prev <= fb_we && !fb_ready;
      st_addr    <= fb_addr;
      st_data    <= fb_data;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    chipselect = 1'b1;
    read       = 1'b1;
    address    = a;
    #1;
    d          = readdata;
    chipselect = 1'b0;
    read       = 1'b0;
  endtask

  task automatic setup_rect(input logic [9:0] x, input logic [8:0] y,
                            input logic [9:0] w, input logic [8:0] h, input logic [7:0] c);
    wr(4'd0, c);
    wr(4'd1, {6'b0, x[9:8]});
    wr(4'd2, x[7:0]);
    wr(4'd3, {7'b0, y[8]});
    wr(4'd4, y[7:0]);
    wr(4'd5, {6'b0, w[9:8]});
    wr(4'd6, w[7:0]);
    wr(4'd7, {7'b0, h[8]});
    wr(4'd8, h[7:0]);
  endtask

  // Poll busy until it drops or the budget runs out; optionally jitter fb_ready.
  task automatic wait_idle(input string tag, input int max_cycles, input bit jitter);
    logic [7:0] d;
    for (int i = 0; i < max_cycles; i++) begin
      rd(4'd9, d);
      if (!d[0]) break;
      if (jitter) fb_ready = 1'($urandom_range(0, 1));
      tick(1);
    end
    fb_ready = 1'b1;
    rd(4'd9, d);
    check({tag, "_idle"}, {31'b0, d[0]}, 32'd0);
  endtask

  task automatic check_fill(input string tag, input logic [18:0] exp_a[$], input logic [7:0] exp_d);
    logic [26:0] got;
    check({tag, "_count"}, acc_q.size(), exp_a.size());
    for (int i = 0; i < exp_a.size(); i++) begin
      got = (i < acc_q.size()) ? acc_q[i] : 27'bx;
      check($sformatf("%s_px%0d", tag, i), {5'b0, got}, {5'b0, exp_a[i], exp_d});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;

    // Reset asserted before any clock edge: outputs must clear asynchronously.
    #2 reset_n = 1'b0;
    #3;
    check("rst_fb_we", {31'b0, fb_we}, 32'd0);
    check("rst_fb_addr", {13'b0, fb_addr}, 32'd0);
    check("rst_fb_data", {24'b0, fb_data}, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    rd(4'd9, d); check("rst_status", {24'b0, d}, 32'd0);
    rd(4'd2, d); check("rst_x_lo", {24'b0, d}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    tick(1);

    // Register readback: unused hi bits dropped, unmapped addresses read 0.
    wr(4'd1, 8'hFF); rd(4'd1, d); check("x_hi_mask", {24'b0, d}, 32'h03);
    wr(4'd3, 8'hFF); rd(4'd3, d); check("y_hi_mask", {24'b0, d}, 32'h01);
    wr(4'd7, 8'hFF); rd(4'd7, d); check("h_hi_mask", {24'b0, d}, 32'h01);
    wr(4'hF, 8'hAA); rd(4'hF, d); check("addr15_zero", {24'b0, d}, 32'd0);
    rd(4'd12, d); check("addr12_zero", {24'b0, d}, 32'd0);

    // 2x3 fill at the origin: start latency, column-major order, done flag.
    setup_rect(10'd0, 9'd0, 10'd2, 9'd3, 8'hFF);
    acc_q.delete();
    wr(4'd9, 8'h01);
    check("t1_we_setup", {31'b0, fb_we}, 32'd0);
    rd(4'd9, d); check("t1_busy", {24'b0, d}, 32'h01);
    tick(1);
    check("t1_we_first", {31'b0, fb_we}, 32'd1);
    check("t1_addr_first", {13'b0, fb_addr}, 32'd0);
    check("t1_data_first", {24'b0, fb_data}, 32'hFF);
    wait_idle("t1", 50, 1'b0);
    check_fill("t1", exp_a1, 8'hFF);
    rd(4'd9, d); check("t1_done", {24'b0, d}, 32'h02);
    check("t1_irq", {31'b0, irq}, {31'b0, IRQ_EN});
    check("t1_we_after", {31'b0, fb_we}, 32'd0);

    // Corner rectangle clipped to 2x2 at the bottom-right of the screen.
    setup_rect(10'd638, 9'd478, 10'd10, 9'd10, 8'h5A);
    acc_q.delete();
    wr(4'd9, 8'h01);
    tick(1);
    check("t2_addr_first", {13'b0, fb_addr}, 32'd306718);
    wait_idle("t2", 50, 1'b0);
    check_fill("t2", exp_a2, 8'h5A);

    // Clear done, then a zero-width fill: no writes, busy for three cycles.
    wr(4'd9, 8'h02);
    rd(4'd9, d); check("t3_cleared", {24'b0, d}, 32'd0);
    check("t3_irq_cleared", {31'b0, irq}, 32'd0);
    setup_rect(10'd5, 9'd5, 10'd0, 9'd4, 8'h77);
    acc_q.delete();
    wr(4'd9, 8'h01);
    rd(4'd9, d); check("t3_busy_setup", {24'b0, d}, 32'h01);
    tick(1);
    rd(4'd9, d); check("t3_busy_done", {24'b0, d}, 32'h01);
    tick(1);
    rd(4'd9, d); check("t3_idle_done", {24'b0, d}, 32'h02);
    check("t3_irq", {31'b0, irq}, {31'b0, IRQ_EN});
    check("t3_no_writes", acc_q.size(), 32'd0);

    // Clear-done landing on the completion edge: done must stay set.
    wr(4'd9, 8'h02);
    rd(4'd9, d); check("t4_cleared", {24'b0, d}, 32'd0);
    wr(4'd9, 8'h01);
    wr(4'd9, 8'h00);
    wr(4'd9, 8'h02);
    rd(4'd9, d); check("t4_done_wins", {24'b0, d}, 32'h02);

    // 4x4 fill with random back-pressure; registers rewritten and restart tried mid-fill.
    setup_rect(10'd10, 9'd20, 10'd4, 9'd4, 8'h3C);
    acc_q.delete();
    fb_ready = 1'b0;
    wr(4'd9, 8'h01);
    for (int i = 0; i < 3; i++) begin
      fb_ready = 1'($urandom_range(0, 1));
      tick(1);
    end
    fb_ready = 1'($urandom_range(0, 1));
    wr(4'd2, 8'h00);
    fb_ready = 1'($urandom_range(0, 1));
    wr(4'd9, 8'h01);
    wait_idle("t5", 300, 1'b1);
    check_fill("t5", exp_a5, 8'h3C);
    rd(4'd2, d); check("t5_reg_updated", {24'b0, d}, 32'h00);

    // Reset mid-fill: outputs drop without a clock, nothing is written afterwards.
    setup_rect(10'd0, 9'd0, 10'd4, 9'd4, 8'h11);
    acc_q.delete();
    wr(4'd9, 8'h01);
    tick(4);
    check("t6_pre_reset_accepts", acc_q.size(), 32'd3);
    #3 reset_n = 1'b0;
    #1;
    check("t6_we_async", {31'b0, fb_we}, 32'd0);
    check("t6_addr_async", {13'b0, fb_addr}, 32'd0);
    rd(4'd9, d); check("t6_status_async", {24'b0, d}, 32'd0);
    rd(4'd0, d); check("t6_color_async", {24'b0, d}, 32'd0);
    reset_n = 1'b1;
    tick(20);
    check("t6_no_writes_after", acc_q.size(), 32'd3);
    check("t6_we_after", {31'b0, fb_we}, 32'd0);
    rd(4'd9, d); check("t6_status_after", {24'b0, d}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_rect_fill.md
FB_RECT_FILL -- requirements
Module: fb_rect_fill

Interface
REQ-001 clk  input  1  system clock (50 MHz), all logic on rising edge.
REQ-002 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-003 chipselect  input  1  Avalon-MM slave select.
REQ-004 write  input  1  Avalon write strobe, qualified by chipselect.
REQ-005 read  input  1  Avalon read strobe, qualified by chipselect; zero wait states.
REQ-006 address  input  4  register index.
REQ-007 writedata  input  8  register write data.
REQ-008 readdata  output  8  register read data, combinational from address.
REQ-009 fb_we  output  1  framebuffer write request to the pixel/VGA stage memory.
REQ-010 fb_addr  output  19  framebuffer word address, column-major: y + x*480.
REQ-011 fb_data  output  8  pixel intensity to write.
REQ-012 fb_ready  input  1  downstream accepts the write on a clk edge where fb_we=1 and fb_ready=1.
REQ-013 irq  output  1  completion interrupt, level, active-high.

Function
REQ-014 Registers: 0 color; 1/2 x hi/lo (x[9:0]); 3/4 y hi/lo (y[8:0]); 5/6 w hi/lo (w[9:0]); 7/8 h hi/lo (h[8:0]); 9 control/status. Unused hi bits ignored on write, read as 0.
REQ-015 Write to reg 9: bit0=1 starts a fill; bit1=1 clears done.
REQ-016 Read reg 9: bit0 busy, bit1 done; other addresses read back their register; addresses 10-15 read 0.
REQ-017 FSM states IDLE, SETUP, FILL, DONE.
REQ-018 IDLE->SETUP on start; start while not IDLE is ignored.
REQ-019 SETUP (1 cycle) latches color, clips: x_end=min(x+w,640), y_end=min(y+h,480), computes base = y + x*480 with 19-bit arithmetic and no hardware multiplier (shift/subtract).
REQ-020 SETUP->DONE directly if w=0, h=0, x>=640 or y>=480 (no writes); else SETUP->FILL.
REQ-021 Start write accepted on edge N; first fb_we=1 at edge N+2.
REQ-022 FILL: fb_we=1; fb_addr/fb_data held stable until accepted; per accept, row increments (addr+1); at last row, column increments and addr = next column base (column base +480).
REQ-023 fb_ready low stalls with no lost or duplicated pixel; a single-pixel fill completes in one accept.
REQ-024 Accept of last pixel (x_end-1, y_end-1) -> DONE; fb_we=0 in DONE.
REQ-025 DONE (1 cycle) sets done flag -> IDLE; busy=1 in SETUP, FILL, DONE.
REQ-026 Register writes during a fill update registers but not the latched fill parameters.
REQ-027 Clear-done and completion in the same cycle: done ends set.

Reset
REQ-028 reset_n low: FSM IDLE, fb_we=0, fb_addr=0, fb_data=0, irq=0, done=0, all registers 0, independent of clk.
REQ-029 Reset during FILL abandons the fill; no write is issued after release until a new start.

Configuration
REQ-030 FB_RECT_FILL_IRQ_EN defined: irq = done, cleared by control bit1 or reset.
REQ-031 FB_RECT_FILL_IRQ_EN undefined: irq tied 0; done status still readable and clearable.

Structure
REQ-032 Package fb_pkg holds H_RES=640, V_RES=480, FB_DEPTH=307200, typedefs fb_addr_t (19 bit), pixel_t (8 bit), fill_state_t enum.
REQ-033 Single sub-module fb_fill_regs implements the Avalon register file and status readback; FSM and address generator in top.

Verification
REQ-034 x=0,y=0,w=2,h=3,color=0xFF, fb_ready=1 -> addresses 0,1,2,480,481,482 data 0xFF, first fb_we 2 cycles after start, done=1.
REQ-035 x=638,y=478,w=10,h=10 -> clipped to 4 writes: 306718,306719,307198,307199.
REQ-036 w=0 start -> no fb_we, busy clears after 3 cycles, done=1, irq=1 with FB_RECT_FILL_IRQ_EN.
REQ-037 fb_ready toggled pseudo-randomly on 4x4 fill -> exactly 16 unique accepts, fb_addr/fb_data stable while stalled.
REQ-038 reset_n pulsed low mid-FILL -> fb_we=0 immediately, busy=0, no writes after release; second start during busy ignored.
